// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle Hack-style ALU.
//   op_e    - encoding of the 3-bit f op select
//   state_e - control FSM states
//   flags_t - registered result flags {zr, ng, cy, ov}
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSX = 3'b101,
    OP_MUL   = 3'b110,
    OP_PASSY = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic zr;
    logic ng;
    logic cy;
    logic ov;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       latch x/y, clear accumulator and counter
//   x, y        WIDTH-bit operands (sampled on start)
//   done        high during the final (WIDTH-th) iteration cycle
//   prod        accumulator value including the current cycle's partial
//               product; equals x*y while done is high
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mx_q;
  logic [WIDTH-1:0]   my_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic               run_q;

  assign acc_d = my_q[0] ? acc_q + mx_q : acc_q;
  // Exposing the next accumulator lets the top capture the result on the
  // same edge as the last iteration, keeping latency at WIDTH+1.
  assign prod  = acc_d;
  assign done  = run_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx_q  <= '0;
      my_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      mx_q  <= {{WIDTH{1'b0}}, x};
      my_q  <= y;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      mx_q  <= mx_q << 1;
      my_q  <= my_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered Hack-style ALU with valid/ready handshake on both sides
// and a multi-cycle multiply.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           operation handshake
//   a, b                          operands
//   zx, zy, nx, ny, no            Hack zero/negate controls
//   f                             op select (see alu_pkg::op_e)
//   out_valid / out_ready         result handshake
//   out, zr, ng, cy, ov           registered result and flags
//   busy                          multiply in progress
//
// state | meaning
// IDLE  | no result held, ready for any op
// MUL   | multiply iterating, input stalled
// HOLD  | result valid, waiting for out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             zx,
  input  logic             zy,
  input  logic             nx,
  input  logic             ny,
  input  logic             no,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  flags_t             flags_q, flags_d;
  logic               no_q;

  logic [WIDTH-1:0]   x_pre, y_pre, r, res;
  logic [WIDTH:0]     sum_ext;
  logic               cy_r, ov_r, inv;
  logic               load, load_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .x     (x_pre),
    .y     (y_pre),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    x_pre   = zx ? '0 : a;
    y_pre   = zy ? '0 : b;
    if (nx) x_pre = ~x_pre;
    if (ny) y_pre = ~y_pre;
    sum_ext = '0;
    r       = '0;
    cy_r    = 1'b0;
    ov_r    = 1'b0;
    case (op_e'(f))
      OP_ADD: begin
        sum_ext = {1'b0, x_pre} + {1'b0, y_pre};
        r       = sum_ext[WIDTH-1:0];
        cy_r    = sum_ext[WIDTH];
        ov_r    = (x_pre[WIDTH-1] == y_pre[WIDTH-1]) && (r[WIDTH-1] != x_pre[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, x_pre} + {1'b0, ~y_pre} + (WIDTH+1)'(1);
        r       = sum_ext[WIDTH-1:0];
        cy_r    = sum_ext[WIDTH];
        ov_r    = (x_pre[WIDTH-1] != y_pre[WIDTH-1]) && (r[WIDTH-1] != x_pre[WIDTH-1]);
      end
      OP_AND:   r = x_pre & y_pre;
      OP_OR:    r = x_pre | y_pre;
      OP_XOR:   r = x_pre ^ y_pre;
      OP_PASSX: r = x_pre;
      OP_PASSY: r = y_pre;
      default:  r = '0;
    endcase
  end

  // The no control of a multiply was captured at acceptance in no_q.
  always_comb begin
    res           = load_mul ? mul_prod[WIDTH-1:0] : r;
    inv           = load_mul ? no_q : no;
    out_d         = inv ? ~res : res;
    flags_d.zr    = (out_d == '0);
    flags_d.ng    = out_d[WIDTH-1];
    flags_d.cy    = load_mul ? (|mul_prod[2*WIDTH-1:WIDTH]) : cy_r;
    flags_d.ov    = load_mul ? 1'b0 : ov_r;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      MUL: begin
        busy = 1'b1;
        if (mul_done) begin
          load     = 1'b1;
          load_mul = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new acceptance overrides the drain-to-IDLE decision above.
    if (in_valid && in_ready) begin
      if (op_e'(f) == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = MUL;
      end else begin
        load    = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      flags_q <= '0;
      no_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_q   <= out_d;
        flags_q <= flags_d;
      end
      if (mul_start) no_q <= no;
    end
  end

  assign out = out_q;
  assign zr  = flags_q.zr;
  assign ng  = flags_q.ng;
  assign cy  = flags_q.cy;
  assign ov  = flags_q.ov;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010,
                         F_XOR = 3'b100, F_MUL = 3'b110, F_PY  = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        zx, zy, nx, ny, no;
  logic [2:0]  f;
  logic        out_valid, out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .zx        (zx),
    .zy        (zy),
    .nx        (nx),
    .ny        (ny),
    .no        (no),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .ov        (ov),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single edge; returns #1 after that edge.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_,
                       input logic [4:0] ctl, input logic [2:0] tf);
    a = ta; b = tb_; {zx, zy, nx, ny, no} = ctl; f = tf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] eo, input logic [3:0] ef);
    check({tag, "_valid"}, {15'b0, out_valid}, 16'h0001);
    check({tag, "_out"}, out, eo);
    check({tag, "_flags"}, {12'b0, zr, ng, cy, ov}, {12'b0, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; {zx, zy, nx, ny, no} = '0; f = F_ADD;
    #1;
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_busy",  {15'b0, busy}, 16'h0000);
    check("rst_out",   out, 16'h0000);
    check("rst_flags", {12'b0, zr, ng, cy, ov}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {15'b0, in_ready}, 16'h0001);

    // Back-to-back single-cycle ops, flags {zr,ng,cy,ov}
    issue(16'd5,    16'd3,    5'b00000, F_ADD); check_res("add53",   16'h0008, 4'b0000);
    issue(16'h1234, 16'h5678, 5'b11100, F_ADD); check_res("addm1",   16'hFFFF, 4'b0100);
    issue(16'h7FFF, 16'h0001, 5'b00000, F_ADD); check_res("add_ov",  16'h8000, 4'b0101);
    issue(16'hFFFF, 16'h0001, 5'b00000, F_ADD); check_res("add_cy",  16'h0000, 4'b1010);
    issue(16'd3,    16'd5,    5'b00000, F_SUB); check_res("sub35",   16'hFFFE, 4'b0100);
    issue(16'd5,    16'd3,    5'b00000, F_SUB); check_res("sub53",   16'h0002, 4'b0010);
    issue(16'hFF00, 16'h0F0F, 5'b00001, F_AND); check_res("and_no",  16'hF0FF, 4'b0100);
    issue(16'h1234, 16'h0000, 5'b00000, F_PY);  check_res("passy0",  16'h0000, 4'b1000);

    // Multiply: result exactly 17 edges after the accept cycle
    issue(16'd300, 16'd300, 5'b00000, F_MUL);
    for (int i = 0; i < 16; i++) begin
      check("mul_busy",     {15'b0, busy}, 16'h0001);
      check("mul_in_ready", {15'b0, in_ready}, 16'h0000);
      check("mul_valid",    {15'b0, out_valid}, 16'h0000);
      @(posedge clk); #1;
    end
    check_res("mul300", 16'h5F90, 4'b0010);
    check("mul_busy_end", {15'b0, busy}, 16'h0000);

    // Drain, then backpressure
    @(posedge clk); #1;
    check("drain_valid", {15'b0, out_valid}, 16'h0000);
    out_ready = 1'b0;
    issue(16'd1, 16'd1, 5'b00000, F_ADD);
    check_res("bp_add", 16'h0002, 4'b0000);
    a = 16'hF0F0; b = 16'hFF00; f = F_XOR; {zx, zy, nx, ny, no} = '0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {15'b0, in_ready}, 16'h0000);
      check("bp_hold_out", out, 16'h0002);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", {15'b0, in_ready}, 16'h0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_res("bp_xor", 16'h0FF0, 4'b0000);

    // Reset in the 5th multiply cycle
    issue(16'd300, 16'd300, 5'b00000, F_MUL);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", {15'b0, busy}, 16'h0001);
    rst_n = 1'b0; #1;
    check("mrst_valid", {15'b0, out_valid}, 16'h0000);
    check("mrst_busy",  {15'b0, busy}, 16'h0000);
    check("mrst_out",   out, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("mrst_no_result", {15'b0, out_valid}, 16'h0000);
    end
    check("mrst_in_ready", {15'b0, in_ready}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the combinational Hack-style ALU. It registers the result and extends the op set with XOR, pass-through and a multi-cycle shift-add multiply. It adds carry and overflow flags and valid/ready flow control on both sides. It sits between the decode stage and the writeback register, and can stall either one.

## Interface
- WIDTH, 16: datapath width in bits, ≥4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a, b  in  WIDTH  operands
- zx, zy, nx, ny, no  in  1 each  zero/negate controls, Hack semantics
- f  in  3  op: 000 add, 001 sub (x−y), 010 and, 011 or, 100 xor, 101 pass x, 110 mul, 111 pass y
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- out  out  WIDTH  result
- zr, ng, cy, ov  out  1 each  flags for out
- busy  out  1  multiply in progress

## Operation
- Preprocessing applies at acceptance, in this order: zx zeroes x; zy zeroes y; nx inverts x; ny inverts y.
- Core op gives r. Then out = no ? ~r : r.
- zr = (out == 0). ng = out[WIDTH-1]. Both are taken after the no step.
- cy:
  - add: carry out of x+y.
  - sub: carry out of x+~y+1 (1 = no borrow).
  - mul: 1 when the upper WIDTH bits of the 2·WIDTH product are non-zero.
  - all other ops: 0.
- ov:
  - add/sub: two's-complement overflow.
  - all other ops: 0.
- cy and ov come from r and ignore no.
- mul returns the low WIDTH bits of the unsigned product x·y.
- The FSM states are IDLE, MUL and HOLD.
  - IDLE: in_ready = !out_valid || out_ready.
    - On acceptance of a non-mul op, load the output register and go to HOLD.
    - On acceptance of a mul op, latch x and y, clear the accumulator and counter, and go to MUL.
  - MUL: in_ready = 0 and busy = 1.
    - Each cycle: if y[0], add x into the accumulator; shift x left and y right; increment the counter.
    - After WIDTH iterations, load the output register and go to HOLD.
  - HOLD: out_valid = 1. out and flags stay stable until out_ready.
    - On out_ready without new acceptance, go to IDLE.
    - A new op may be accepted in the same cycle that the result is consumed. This keeps 1 op/cycle throughput for single-cycle ops.
- in_ready is 1 in HOLD when out_ready = 1, and 0 otherwise.
- in_valid while in_ready = 0 is ignored. The offer is not latched.

## Timing
- Reset, asynchronous and immediate:
  - state IDLE, out_valid 0, busy 0.
  - out = 0 and all flags = 0.
  - multiplier registers and counter = 0.
  - in_ready = 1 after reset releases.
- Non-mul latency is 1: accepted at edge N, out_valid at N+1.
- Mul latency is WIDTH+1: accepted at N, out_valid at N+WIDTH+1. busy is high for WIDTH cycles.
- Back-to-back single-cycle ops with out_ready held at 1 give one result per cycle.
- Reset during MUL discards the operation. No result appears after reset releases.
- Simultaneous result consume and new accept: the new result replaces the old one at that edge, and out_valid stays 1.
- mul with y = 0 still takes WIDTH cycles. Latency is fixed.

## Structure
- Package alu_pkg holds:
  - op_e, the 3-bit enum for f encodings.
  - state_e (IDLE, MUL, HOLD).
  - a flags struct {zr, ng, cy, ov}.
- Sub-module alu_mul_seq is a parametrised shift-add multiplier.
  - Ports: start, x, y, done, prod[2·WIDTH-1:0].
  - The counter has $clog2(WIDTH+1) bits.
- The top level holds the preprocessing, combinational single-cycle ops, the FSM and the output/flag register.

## Test plan
- WIDTH = 16, out_ready = 1:
  - a = 5, b = 3, add → 1 cycle later out = 0x0008, zr 0, ng 0, cy 0, ov 0.
  - zx = zy = nx = 1, add → out = 0xFFFF, ng 1.
- Add a = 0x7FFF, b = 1 → out = 0x8000, ng 1, ov 1, cy 0.
- Add a = 0xFFFF, b = 1 → out = 0, zr 1, cy 1, ov 0.
- Sub a = 3, b = 5 → out = 0xFFFE, cy 0, ng 1.
- Sub a = 5, b = 3 → out = 0x0002, cy 1.
- Mul a = 300, b = 300 → out_valid exactly 17 cycles after accept with out = 0x5F90, cy 1. in_ready 0 and busy 1 throughout the multiply.
- Backpressure: out_ready = 0, accept add 1+1, offer xor a = 0xF0F0, b = 0xFF00 → in_ready 0 and out = 2 held for 5 cycles. Raise out_ready → xor accepted on that edge; next cycle out = 0x0FF0.
- Assert rst_n = 0 in the 5th mul cycle → out_valid, busy and out go to 0 immediately. After release, no result for 20 cycles; in_ready = 1.
